// File: rtl/edge_detect_filt.sv
// Multi-channel edge detector: synchronise, debounce, strobe on selected edges
// and measure the interval between consecutive qualifying edges per channel.
module edge_detect_filt #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 16
) (
  input  logic                clk_50K,
  input  logic                rst_n,
  input  logic [CH-1:0]       signal,
  input  logic [1:0]          mode,
  output logic [CH-1:0]       pulse,
  output logic [CH-1:0]       level,
  output logic [CH*CNT_W-1:0] period,
  output logic [CH-1:0]       period_valid,
  output logic [CH-1:0]       overflow
);

  localparam int FW = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  logic [SYNC_STAGES-1:0] sync_q   [CH];
  logic [FW-1:0]          filt_cnt [CH];
  logic [CNT_W-1:0]       ivl_cnt  [CH];
  logic [CH-1:0]          armed;
  edge_mode_e             mode_e;
  edge_mode_e             mode_q;
  logic                   mode_chg;
  logic [CH-1:0]          sync_out;
  logic [CH-1:0]          toggle;
  logic [CH-1:0]          qual;

  assign mode_e   = edge_mode_e'(mode);
  assign mode_chg = (mode_e != mode_q);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sync_out = '0;
    toggle   = '0;
    qual     = '0;
    for (int i = 0; i < CH; i++) begin
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
      // Level flips on the cycle the mismatch has persisted FILT_LEN cycles.
      toggle[i]   = (sync_out[i] != level[i]) && (filt_cnt[i] == FW'(FILT_LEN - 1));
      case (mode_e)
        EDGE_RISE: qual[i] = toggle[i] && !level[i];
        EDGE_FALL: qual[i] = toggle[i] &&  level[i];
        EDGE_BOTH: qual[i] = toggle[i];
        default:   qual[i] = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_50K or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these arrays are per-channel flops, not RAM, so resetting them
      // is cheap and required for a defined post-reset state.
      for (int i = 0; i < CH; i++) begin
        sync_q[i]   <= '0;
        filt_cnt[i] <= '0;
        ivl_cnt[i]  <= '0;
      end
      armed        <= '0;
      level        <= '0;
      pulse        <= '0;
      period       <= '0;
      period_valid <= '0;
      overflow     <= '0;
      mode_q       <= EDGE_RISE;
    end else begin
      mode_q <= mode_e;
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], signal[i]};

        if (toggle[i]) begin
          level[i]    <= ~level[i];
          filt_cnt[i] <= '0;
        end else if (sync_out[i] != level[i]) begin
          filt_cnt[i] <= filt_cnt[i] + FW'(1);
        end else begin
          filt_cnt[i] <= '0;
        end

        pulse[i]        <= qual[i];
        period_valid[i] <= 1'b0;

        if (mode_e == EDGE_OFF) begin
          ivl_cnt[i] <= '0;
          armed[i]   <= 1'b0;
        end else if (qual[i]) begin
          // Reload to 1 so the count seen at the next edge equals t1 - t0.
          ivl_cnt[i] <= CNT_W'(1);
          if (armed[i] && !mode_chg) begin
            period[i*CNT_W +: CNT_W] <= ivl_cnt[i];
            overflow[i]              <= &ivl_cnt[i];
            period_valid[i]          <= 1'b1;
          end
          armed[i] <= !mode_chg;
        end else begin
          if (!(&ivl_cnt[i])) ivl_cnt[i] <= ivl_cnt[i] + CNT_W'(1);
          if (mode_chg) armed[i] <= 1'b0;
        end
      end
    end
  end

endmodule
